// File: rtl/master_port_pkg.sv
// Shared encodings for the serial bus master port and the slave ports it drives:
// transaction state enum, mode constants and a small elaboration helper.
package master_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    DONE
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load shift register: MSB-first shift-out on msb_o, shift-in at the LSB.
// Loading takes priority over shifting.
module serial_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             in_bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic             msb_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= (data_q << 1) | WIDTH'(in_bit_i);
    end
  end

  assign data_o = data_q;
  assign msb_o  = data_q[WIDTH-1];

endmodule

// File: rtl/master_port.sv
// Serial bus master port: serialises one local read/write request MSB-first onto
// the 1-bit bus and collects read data. Optional read timeout: MASTER_PORT_TIMEOUT_EN.
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dev_req,
  input  logic                  dev_mode,
  input  logic [ADDR_WIDTH-1:0] dev_addr,
  input  logic [DATA_WIDTH-1:0] dev_wdata,
  output logic                  dev_ready,
  output logic                  dev_done,
  output logic                  dev_err,
  output logic [DATA_WIDTH-1:0] dev_rdata,
  output logic                  split_wait,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  split
);

  localparam int TX_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W = $clog2(TX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("master_port: ADDR_WIDTH, DATA_WIDTH and TIMEOUT_CYCLES must be >= 1");
  end

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  seen_ready_q;
  logic                  err_q;
  logic                  split_q;

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  logic            tx_load;
  logic [TX_W-1:0] tx_load_val;
  logic            tx_shift;
  logic            tx_msb;
  logic [TX_W-1:0] tx_word_unused;
  logic            rx_load;
  logic            rx_shift;
  logic            rx_msb_unused;

  // Transaction sequencer. Any low slave_ready once a bit has been accepted is an abort.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: every register in this block, the latched request included, is cleared by the
    // async reset so a mid-transfer reset leaves no stale mode/err/split state behind.
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_q       <= MODE_READ;
      wdata_q      <= '0;
      seen_ready_q <= 1'b0;
      err_q        <= 1'b0;
      split_q      <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every branch reads the pre-edge register values.
      case (state_q)
        IDLE: begin
          if (dev_req) begin
            mode_q       <= dev_mode;
            wdata_q      <= dev_wdata;
            cnt_q        <= '0;
            seen_ready_q <= 1'b0;
            err_q        <= 1'b0;
            split_q      <= 1'b0;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          if (slave_ready) begin
            seen_ready_q <= 1'b1;
            if (cnt_q == ADDR_LAST) begin
              cnt_q   <= '0;
              state_q <= (mode_q == MODE_WRITE) ? WDATA : RWAIT;
`ifdef MASTER_PORT_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (seen_ready_q) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        WDATA: begin
          if (slave_ready) begin
            if (cnt_q == DATA_LAST) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (seen_ready_q) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        RWAIT: begin
          if (split) split_q <= 1'b1;
          if (slave_valid) begin
            if (DATA_LAST == '0) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= CNT_W'(1);
              state_q <= RDATA;
            end
          end
`ifdef MASTER_PORT_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        RDATA: begin
          if (split) split_q <= 1'b1;
          if (slave_valid) begin
            if (cnt_q == DATA_LAST) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          split_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shifter control: the address is loaded on acceptance, write data after the last address bit.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a control signal unassigned.
    tx_load     = 1'b0;
    tx_load_val = '0;
    tx_shift    = 1'b0;
    rx_load     = 1'b0;
    rx_shift    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dev_req) begin
          tx_load     = 1'b1;
          tx_load_val = TX_W'(dev_addr) << (TX_W - ADDR_WIDTH);
          rx_load     = 1'b1;
        end
      end
      ADDR: begin
        if (slave_ready) begin
          if (cnt_q == ADDR_LAST) begin
            tx_load     = 1'b1;
            tx_load_val = TX_W'(wdata_q) << (TX_W - DATA_WIDTH);
          end else begin
            tx_shift = 1'b1;
          end
        end
      end
      WDATA:        tx_shift = slave_ready;
      RWAIT, RDATA: rx_shift = slave_valid;
      default: ;
    endcase
  end

  serial_shifter #(.WIDTH(TX_W)) u_tx_shifter (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (tx_load),
    .load_val_i (tx_load_val),
    .shift_i    (tx_shift),
    .in_bit_i   (1'b0),
    .data_o     (tx_word_unused),
    .msb_o      (tx_msb)
  );

  // The read word accumulates in place and is cleared on acceptance, so it holds until the next request.
  serial_shifter #(.WIDTH(DATA_WIDTH)) u_rx_shifter (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (rx_load),
    .load_val_i ('0),
    .shift_i    (rx_shift),
    .in_bit_i   (rd_bus),
    .data_o     (dev_rdata),
    .msb_o      (rx_msb_unused)
  );

  assign dev_ready    = (state_q == IDLE);
  assign dev_done     = (state_q == DONE);
  assign dev_err      = err_q;
  assign split_wait   = split_q;
  assign mode         = mode_q;
  assign master_valid = (state_q == ADDR) || (state_q == WDATA);
  assign master_ready = (state_q == RWAIT) || (state_q == RDATA);
  assign wr_bus       = master_valid & tx_msb;

endmodule

// File: doc/master_port.md
# master_port

Serial bus master port: accepts one parallel read or write request from a local master and serialises it MSB-first onto the 1-bit system bus. It sits directly upstream of the slave ports and drives their `mode`, `wr_bus`, `master_valid` and `master_ready` inputs. For reads it collects the slave's serial response into a parallel word. It also tolerates split slaves and reports aborted transfers.

## Interface
- `ADDR_WIDTH`, 16, address bits shifted per transaction
- `DATA_WIDTH`, 8, data bits shifted per transaction
- `TIMEOUT_CYCLES`, 64, read-wait limit; used only with `MASTER_PORT_TIMEOUT_EN`
- `clk` in 1: single clock; all logic on posedge
- `rstn` in 1: reset, asynchronous and active-low
- `dev_req` in 1: local request strobe
- `dev_mode` in 1: 1 = write, 0 = read
- `dev_addr` in ADDR_WIDTH: request address
- `dev_wdata` in DATA_WIDTH: write data
- `dev_ready` out 1: port idle, request accepted this cycle if `dev_req`
- `dev_done` out 1: one-cycle completion pulse
- `dev_err` out 1: qualifies `dev_done`; transfer aborted
- `dev_rdata` out DATA_WIDTH: read result, valid with `dev_done`, held until next acceptance
- `split_wait` out 1: slave has signalled split during current read
- `mode` out 1: latched `dev_mode`, held for whole transaction
- `wr_bus` out 1: serial address/data bit
- `master_valid` out 1: bit on `wr_bus` is valid
- `master_ready` out 1: master accepts `rd_bus` bits
- `rd_bus` in 1: serial read data from slave
- `slave_ready` in 1: slave sampling `wr_bus` this cycle
- `slave_valid` in 1: `rd_bus` bit valid
- `split` in 1: slave in split wait

## Operation
- States:
  - IDLE: `dev_ready`=1. When `dev_req`=1, latch addr, wdata and mode, clear the bit counter, clear `split_wait` and `dev_err`, then go to ADDR.
  - ADDR: `master_valid`=1, `wr_bus`=addr[ADDR_WIDTH-1-cnt]. A bit transfers in any cycle with `slave_ready`=1; cnt then increments. After bit ADDR_WIDTH-1 transfers, clear cnt and go to WDATA if mode=1, else RWAIT.
  - WDATA: `master_valid`=1, `wr_bus`=wdata[DATA_WIDTH-1-cnt], same per-bit handshake. After the last bit go to DONE.
  - RWAIT: `master_valid`=0, `master_ready`=1. `split`=1 sets `split_wait` (sticky until DONE). When `slave_valid`=1, capture the bit in the same cycle and go to RDATA.
  - RDATA: `master_ready`=1. Every cycle with `slave_valid`=1, shift `rd_bus` into rdata LSB; cnt increments. After DATA_WIDTH bits go to DONE.
  - DONE: `dev_done`=1 for one cycle, then IDLE.
- Abort: in ADDR or WDATA, `slave_ready` 1→0 after having been seen high in this transaction means the slave returned to idle. Go to DONE with `dev_err`=1. A low `slave_ready` before the first accepted bit is a plain wait, not an abort.
- `slave_valid`, `rd_bus` and `split` are ignored outside RWAIT/RDATA. Trailing slave_valid cycles after the last bit are harmless.
- `wr_bus`=0 whenever `master_valid`=0.
- Bit counter width: $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1).
- Reset (any time, mid-transfer included): state IDLE; all bus outputs 0; `dev_ready`=1; `dev_done`, `dev_err`, `split_wait` =0; `dev_rdata`=0; latched registers cleared.

## Timing
- Acceptance edge = cycle 0. ADDR starts at cycle 1.
- Ideal slave (ready one cycle after valid): write `dev_done` at cycle 2+ADDR_WIDTH+DATA_WIDTH (26 at default widths).
- Read `dev_done` = one cycle after the last `rd_bus` bit is captured.
- `dev_ready` is low from cycle 1 through DONE. Back-to-back requests are possible one cycle after `dev_done`.
- All outputs are registered or decoded from state/registers only; there is no combinational path from bus inputs to bus outputs.

## Configuration
- `MASTER_PORT_TIMEOUT_EN` defined: a cycle counter runs in RWAIT, including during split. Reaching TIMEOUT_CYCLES goes to DONE with `dev_err`=1 and `dev_rdata`=0. The counter is cleared on entry to RWAIT.
- Undefined: RWAIT waits indefinitely; the counter logic is absent and TIMEOUT_CYCLES is unused.

## Structure
- `master_port_pkg`: state enum (IDLE, ADDR, WDATA, RWAIT, RDATA, DONE), MODE_READ=0 / MODE_WRITE=1 constants. Bus-side slave ports share these.
- Sub-module `serial_shifter`: parameterised width. Load, MSB-first shift-out and shift-in into LSB. One instance for address/data out, one for read data in.

## Test plan
- Write 0xA5 to 0x1234, slave ready from cycle 2: `wr_bus` carries 0x1234 then 0xA5 MSB-first; `dev_done` at cycle 26; `dev_err`=0.
- Read 0x00FF, slave returns 0x3C after 4 cycles: `master_ready`=1 throughout RWAIT/RDATA; `dev_rdata`=0x3C; `dev_err`=0.
- Read with `split`=1 for 10 cycles before `slave_valid`: `split_wait`=1 until DONE; data 0xC3 captured correctly.
- `slave_ready` drops after 5 address bits: DONE with `dev_err`=1, no WDATA bits driven.
- `rstn` low mid-WDATA: all outputs at reset values immediately (async); next request completes normally.
- With `MASTER_PORT_TIMEOUT_EN` and TIMEOUT_CYCLES=64, slave never valid: `dev_done` with `dev_err`=1 and `dev_rdata`=0 after 64 RWAIT cycles.
